program_loader: RTL and testbench



---
 rtl/program_loader_pkg.sv | 18 +
 rtl/program_loader_byte_pair_assembler.sv | 35 +++
 rtl/program_loader.sv | 152 +++++++++++++++
 tb/tb_program_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the runtime program loader: byte width, default memory size,
// and the loader FSM state encoding.
package program_loader_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned data_size = 65535;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/program_loader_byte_pair_assembler.sv
// Collects two stream bytes, high byte first, into a 16-bit word. The phase flag
// tracks which half the next byte lands in; complete marks the low-byte transfer.
module program_loader_byte_pair_assembler
  import program_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  shift,
  input  logic [BYTE_W-1:0]     byte_in,
  output logic [2*BYTE_W-1:0]   word,
  output logic                  complete
);

  logic phase_q;  // 0: next byte is the high byte

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word    <= '0;
      phase_q <= 1'b0;
    end else if (clr) begin
      phase_q <= 1'b0;
    end else if (shift) begin
      if (phase_q) begin
        word[BYTE_W-1:0] <= byte_in;
      end else begin
        word[2*BYTE_W-1:BYTE_W] <= byte_in;
      end
      phase_q <= ~phase_q;
    end
  end

  assign complete = shift && phase_q;

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed, big-endian byte image into instruction memory through its
// write port, stalling the CPU for the duration of the load.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned             ADDR_W    = 16,
  parameter int unsigned             DATA_W    = 16,
  parameter int unsigned             MEM_DEPTH = data_size + 1,
  parameter logic [ADDR_W-1:0]       BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BYTE_W-1:0]   byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic [DATA_W-1:0]   mem_instruction,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_write,
  output logic                cpu_stall,
  output logic                done,
  output logic                error,
  output logic [ADDR_W:0]     words_loaded
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                stall_q, stall_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                write_q, write_d;

  logic                xfer, load_start, len_shift, data_shift;
  logic                len_complete, data_complete;
  logic [15:0]         len_word, len_full;
  logic [ADDR_W:0]     words_inc;

  assign byte_ready = state_q inside {StLenHi, StLenLo, StDataHi, StDataLo};
  assign xfer       = byte_valid && byte_ready;
  assign load_start = start && (state_q inside {StIdle, StDone});
  assign len_shift  = xfer && (state_q inside {StLenHi, StLenLo});
  assign data_shift = xfer && (state_q inside {StDataHi, StDataLo});
  assign len_full   = {len_word[15:8], byte_in};
  assign words_inc  = words_q + 1'b1;

  program_loader_byte_pair_assembler u_len_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (load_start),
    .shift    (len_shift),
    .byte_in  (byte_in),
    .word     (len_word),
    .complete (len_complete)
  );

  program_loader_byte_pair_assembler u_data_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (load_start),
    .shift    (data_shift),
    .byte_in  (byte_in),
    .word     (mem_instruction),
    .complete (data_complete)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    stall_d = stall_q;
    done_d  = done_q;
    error_d = error_q;
    write_d = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (load_start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          words_d = '0;
          addr_d  = BASE_ADDR;
          stall_d = 1'b1;
          state_d = StLenHi;
        end
      end
      StLenHi: if (xfer) state_d = StLenLo;
      StLenLo: begin
        if (len_complete) begin
          if (len_full == '0) begin
            done_d  = 1'b1;
            stall_d = 1'b0;
            state_d = StDone;
          end else if (32'(len_full) > MEM_DEPTH) begin
            error_d = 1'b1;
            stall_d = 1'b0;
            state_d = StDone;
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: if (xfer) state_d = StDataLo;
      StDataLo: begin
        if (data_complete) begin
          write_d = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        addr_d  = addr_q + 1'b1;
        words_d = words_inc;
        // Remaining count is implicit: length header minus words already written.
        if (words_inc == (ADDR_W+1)'(len_word)) begin
          done_d  = 1'b1;
          stall_d = 1'b0;
          state_d = StDone;
        end else begin
          state_d = StDataHi;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= BASE_ADDR;
      words_q <= '0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      error_q <= error_d;
      write_q <= write_d;
    end
  end

  assign mem_address  = addr_q;
  assign mem_write    = write_q;
  assign cpu_stall    = stall_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued as bytes are
// driven and retired by a write monitor on each DUT.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;

  logic        a_ready, a_write, a_stall, a_done, a_error;
  logic [15:0] a_instr, a_addr;
  logic [16:0] a_words;
  logic        b_ready, b_write, b_stall, b_done, b_error;
  logic [15:0] b_instr, b_addr;
  logic [16:0] b_words;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] a_exp_q[$];
  logic [31:0] b_exp_q[$];
  int          a_wr_cyc[$];
  logic [15:0] a_next_addr, b_next_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  program_loader #(.MEM_DEPTH(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(a_ready), .mem_instruction(a_instr), .mem_address(a_addr),
    .mem_write(a_write), .cpu_stall(a_stall), .done(a_done), .error(a_error),
    .words_loaded(a_words)
  );

  program_loader #(.BASE_ADDR(16'hFFFF)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(b_ready), .mem_instruction(b_instr), .mem_address(b_addr),
    .mem_write(b_write), .cpu_stall(b_stall), .done(b_done), .error(b_error),
    .words_loaded(b_words)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitors retire scoreboard entries at the negedge the memory would capture.
  always @(negedge clk) begin
    if (rst_n && a_write) begin
      check("a_ready_in_write", 32'(a_ready), 32'd0);
      check("a_stall_in_write", 32'(a_stall), 32'd1);
      a_wr_cyc.push_back(cyc);
      if (a_exp_q.size() == 0) check("a_unexpected_write", 32'(a_exp_q.size()), 32'd1);
      else check("a_write", {a_addr, a_instr}, a_exp_q.pop_front());
    end
    if (rst_n && b_write) begin
      check("b_stall_in_write", 32'(b_stall), 32'd1);
      if (b_exp_q.size() == 0) check("b_unexpected_write", 32'(b_exp_q.size()), 32'd1);
      else check("b_write", {b_addr, b_instr}, b_exp_q.pop_front());
    end
  end

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input bit rnd);
    int n;
    if (rnd) begin
      n = $urandom_range(2, 0);
      byte_valid = 1'b0;
      repeat (n) @(negedge clk);
    end
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    while (!(sel ? b_ready : a_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'(n), 32'd0);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [15:0] w, input bit rnd);
    if (sel) begin
      b_exp_q.push_back({b_next_addr, w});
      b_next_addr = b_next_addr + 16'd1;
    end else begin
      a_exp_q.push_back({a_next_addr, w});
      a_next_addr = a_next_addr + 16'd1;
    end
    send_byte(sel, w[15:8], rnd);
    send_byte(sel, w[7:0], rnd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_a_write", 32'(a_write), 32'd0);
    check("rst_a_instr", 32'(a_instr), 32'd0);
    check("rst_a_addr", 32'(a_addr), 32'h0000);
    check("rst_a_flags", {29'd0, a_stall, a_done, a_error}, 32'd0);
    check("rst_a_words", 32'(a_words), 32'd0);
    check("rst_b_addr", 32'(b_addr), 32'h0000_FFFF);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-word load, byte_valid continuously high.
    a_wr_cyc.delete();
    a_next_addr = 16'h0000;
    pulse_start(1'b0);
    check("t1_stall_start", 32'(a_stall), 32'd1);
    check("t1_ready_lenhi", 32'(a_ready), 32'd1);
    send_byte(1'b0, 8'h00, 1'b0);
    send_byte(1'b0, 8'h02, 1'b0);
    send_word(1'b0, 16'hA1B2, 1'b0);
    send_word(1'b0, 16'hC3D4, 1'b0);
    check("t1_stall_last_write", 32'(a_stall), 32'd1);
    @(negedge clk);
    check("t1_done", 32'(a_done), 32'd1);
    check("t1_stall_after", 32'(a_stall), 32'd0);
    check("t1_words", 32'(a_words), 32'd2);
    check("t1_pending", 32'(a_exp_q.size()), 32'd0);
    if (a_wr_cyc.size() == 2) check("t1_spacing", 32'(a_wr_cyc[1] - a_wr_cyc[0]), 32'd3);
    else check("t1_write_count", 32'(a_wr_cyc.size()), 32'd2);

    // Zero-length header: done two cycles after start, no writes.
    pulse_start(1'b0);
    check("t2_done_cleared", 32'(a_done), 32'd0);
    send_byte(1'b0, 8'h00, 1'b0);
    check("t2_done_early", 32'(a_done), 32'd0);
    check("t2_stall_mid", 32'(a_stall), 32'd1);
    send_byte(1'b0, 8'h00, 1'b0);
    check("t2_done", 32'(a_done), 32'd1);
    check("t2_stall", 32'(a_stall), 32'd0);
    check("t2_words", 32'(a_words), 32'd0);

    // Oversized header (257 > 256).
    pulse_start(1'b0);
    send_byte(1'b0, 8'h01, 1'b0);
    send_byte(1'b0, 8'h01, 1'b0);
    check("t3_error", 32'(a_error), 32'd1);
    check("t3_done", 32'(a_done), 32'd0);
    check("t3_stall", 32'(a_stall), 32'd0);
    check("t3_ready", 32'(a_ready), 32'd0);

    // Four words with random valid gaps.
    a_next_addr = 16'h0000;
    pulse_start(1'b0);
    check("t4_error_cleared", 32'(a_error), 32'd0);
    send_byte(1'b0, 8'h00, 1'b1);
    send_byte(1'b0, 8'h04, 1'b1);
    send_word(1'b0, 16'h1111, 1'b1);
    send_word(1'b0, 16'h2222, 1'b1);
    send_word(1'b0, 16'h3333, 1'b1);
    send_word(1'b0, 16'h4444, 1'b1);
    n = 0;
    while (!a_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t4_done", 32'(a_done), 32'd1);
    check("t4_words", 32'(a_words), 32'd4);
    check("t4_pending", 32'(a_exp_q.size()), 32'd0);

    // Ignored start mid-load, then reset during DATA_LO of word 2.
    a_next_addr = 16'h0000;
    pulse_start(1'b0);
    send_byte(1'b0, 8'h00, 1'b0);
    send_byte(1'b0, 8'h03, 1'b0);
    send_word(1'b0, 16'h1357, 1'b0);
    pulse_start(1'b0);
    check("t5_stall_busy", 32'(a_stall), 32'd1);
    check("t5_words_busy", 32'(a_words), 32'd1);
    send_byte(1'b0, 8'h24, 1'b0);
    check("t5_ready_datalo", 32'(a_ready), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_write", 32'(a_write), 32'd0);
    check("t5_rst_stall", 32'(a_stall), 32'd0);
    check("t5_rst_words", 32'(a_words), 32'd0);
    check("t5_rst_addr", 32'(a_addr), 32'd0);
    check("t5_rst_ready", 32'(a_ready), 32'd0);
    check("t5_pending", 32'(a_exp_q.size()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    a_next_addr = 16'h0000;
    pulse_start(1'b0);
    send_byte(1'b0, 8'h00, 1'b0);
    send_byte(1'b0, 8'h01, 1'b0);
    send_word(1'b0, 16'h5A5A, 1'b0);
    @(negedge clk);
    check("t5_reload_done", 32'(a_done), 32'd1);
    check("t5_reload_words", 32'(a_words), 32'd1);

    // Address wrap from 0xFFFF.
    b_next_addr = 16'hFFFF;
    pulse_start(1'b1);
    send_byte(1'b1, 8'h00, 1'b0);
    send_byte(1'b1, 8'h02, 1'b0);
    send_word(1'b1, 16'h0123, 1'b0);
    send_word(1'b1, 16'h4567, 1'b0);
    @(negedge clk);
    check("t6_done", 32'(b_done), 32'd1);
    check("t6_words", 32'(b_words), 32'd2);
    check("t6_addr_after", 32'(b_addr), 32'h0000_0001);
    check("t6_pending", 32'(b_exp_q.size()), 32'd0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
